// File: rtl/backprop_pkg.sv
// Shared types and constants for the backprop sequencer.
// Control word layout, MSB first: {valid, last, layer_idx, sample_idx}.
package backprop_pkg;

  localparam int unsigned IDX_W  = 32;
  localparam int unsigned CTRL_W = 1 + 1 + IDX_W + IDX_W;

  // Bit offsets into the control word
  localparam int unsigned SAMPLE_LSB = 0;
  localparam int unsigned LAYER_LSB  = IDX_W;
  localparam int unsigned LAST_BIT   = 2 * IDX_W;
  localparam int unsigned VALID_BIT  = 2 * IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bp_state_e;

endpackage

// File: rtl/bp_valid_pipe.sv
// Valid-bit shift register tracking tokens in flight between issue and retire.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift enable (low freezes every stage)
//   in         : valid bit entering stage 0
//   empty      : no stage holds a valid bit
//   out        : tail stage
module bp_valid_pipe #(
  parameter int unsigned PIPE_DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in,
  output logic empty,
  output logic out
);

  logic [PIPE_DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= in;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign empty = ~|sr;
  assign out   = sr[PIPE_DEPTH-1];

endmodule

// File: rtl/backprop_sequencer.sv
// Backprop sequencer: walks layers in descending order, issuing one control
// token per sample, and drains the pipe between layers.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : run request (accepted in IDLE only)
//   layer_count       : layers to process, latched on start
//   sample_count      : samples per layer, latched on start
//   stall             : freezes issue, drain and the valid pipe
//   backprop_controll : issued control word {valid, last, layer_idx, sample_idx}
//   retire_valid      : token leaving the last pipe stage
//   busy              : high while issuing or draining
//   done              : one-cycle completion pulse
//   stall_cycles      : stalled busy cycles, saturating (only with
//                       BACKPROP_SEQ_PERF_EN defined)
module backprop_sequencer #(
  parameter int unsigned PIPE_DEPTH = 6,
  parameter int unsigned IDX_W      = backprop_pkg::IDX_W,
  parameter int unsigned CTRL_W     = 1 + 1 + IDX_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  layer_count,
  input  logic [IDX_W-1:0]  sample_count,
  input  logic              stall,
  output logic [CTRL_W-1:0] backprop_controll,
  output logic              retire_valid,
  output logic              busy,
  output logic              done
`ifdef BACKPROP_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  import backprop_pkg::*;

  localparam int unsigned CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH - 1);

  bp_state_e        state;
  logic [IDX_W-1:0] layer_idx;
  logic [IDX_W-1:0] sample_idx;
  logic [IDX_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] drain_cnt;
  logic             issue_q;
  logic             issue_now;
  logic             is_last;
  logic             pipe_empty;
  logic             start_ok;

  assign issue_now = (state == ISSUE) && !stall;
  assign is_last   = (sample_idx == sample_cnt_q - IDX_W'(1));
  // A new run may not begin while an earlier token is still frozen in the pipe
  assign start_ok  = (state == IDLE) && start && pipe_empty;

  // issue_q remembers the last issued valid bit across a stall so a token
  // issued just before a stall still enters the pipe once it releases; this
  // keeps issue-to-retire at exactly PIPE_DEPTH unstalled edges.
  bp_valid_pipe #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_valid_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall),
    .in    (issue_q),
    .empty (pipe_empty),
    .out   (retire_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      layer_idx         <= '0;
      sample_idx        <= '0;
      sample_cnt_q      <= '0;
      drain_cnt         <= '0;
      issue_q           <= 1'b0;
      backprop_controll <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done              <= 1'b0;
      backprop_controll <= '0;
      if (!stall) begin
        issue_q <= issue_now;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            if ((layer_count != '0) && (sample_count != '0)) begin
              state        <= ISSUE;
              busy         <= 1'b1;
              layer_idx    <= layer_count - IDX_W'(1);
              sample_idx   <= '0;
              sample_cnt_q <= sample_count;
            end else begin
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (!stall) begin
            backprop_controll <= {1'b1, is_last, layer_idx, sample_idx};
            if (is_last) begin
              sample_idx <= '0;
              drain_cnt  <= '0;
              state      <= DRAIN;
            end else begin
              sample_idx <= sample_idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          // Exit on the edge the last token of the layer reaches the tail
          if (!stall) begin
            if (drain_cnt == DRAIN_LAST) begin
              if (layer_idx != '0) begin
                layer_idx <= layer_idx - IDX_W'(1);
                state     <= ISSUE;
              end else begin
                busy  <= 1'b0;
                state <= DONE;
              end
            end else begin
              drain_cnt <= drain_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BACKPROP_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start_ok) begin
      stall_cycles <= '0;
    end else if (busy && stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer (PIPE_DEPTH = 6, IDX_W = 32).
// Cycle index c counts rising edges after the edge that samples start.
module tb_backprop_sequencer;

  import backprop_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic [IDX_W-1:0]  layer_count = '0;
  logic [IDX_W-1:0]  sample_count = '0;
  logic [CTRL_W-1:0] ctrl;
  logic              retire_valid;
  logic              busy;
  logic              done;
`ifdef BACKPROP_SEQ_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  backprop_sequencer #(
    .PIPE_DEPTH (6),
    .IDX_W      (IDX_W),
    .CTRL_W     (CTRL_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .layer_count       (layer_count),
    .sample_count      (sample_count),
    .stall             (stall),
    .backprop_controll (ctrl),
    .retire_valid      (retire_valid),
    .busy              (busy),
    .done              (done)
`ifdef BACKPROP_SEQ_PERF_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CTRL_W-1:0] tok(input bit last, input int unsigned layer,
                                            input int unsigned sample);
    return {1'b1, last, IDX_W'(layer), IDX_W'(sample)};
  endfunction

  task automatic pulse_start(input int unsigned layers, input int unsigned samples);
    layer_count  = IDX_W'(layers);
    sample_count = IDX_W'(samples);
    start        = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests++; if (ctrl !== '0) begin fails++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
    tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL reset_retire: got %b expected 0", retire_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef BACKPROP_SEQ_PERF_EN
    tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  // Two layers of three samples: tokens at c=1..3 (layer 1) and c=10..12 (layer 0)
  task automatic run_two_layer_seq(input string name);
    logic [CTRL_W-1:0] exp_ctrl;
    logic exp_ret, exp_busy, exp_done;
    pulse_start(2, 3);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_c0: got %b expected 1", name, busy); end
    for (int c = 1; c <= 21; c++) begin
      step();
      exp_ctrl = '0;
      if (c >= 1 && c <= 3) exp_ctrl = tok(c == 3, 1, c - 1);
      else if (c >= 10 && c <= 12) exp_ctrl = tok(c == 12, 0, c - 10);
      exp_ret  = (c >= 7 && c <= 9) || (c >= 16 && c <= 18);
      exp_busy = (c <= 17);
      exp_done = (c == 19);
      tests++; if (ctrl !== exp_ctrl) begin fails++; $display("FAIL %s_ctrl c=%0d: got %h expected %h", name, c, ctrl, exp_ctrl); end
      tests++; if (retire_valid !== exp_ret) begin fails++; $display("FAIL %s_retire c=%0d: got %b expected %b", name, c, retire_valid, exp_ret); end
      tests++; if (busy !== exp_busy) begin fails++; $display("FAIL %s_busy c=%0d: got %b expected %b", name, c, busy, exp_busy); end
      tests++; if (done !== exp_done) begin fails++; $display("FAIL %s_done c=%0d: got %b expected %b", name, c, done, exp_done); end
    end
  endtask

  task automatic test_two_layers();
    run_two_layer_seq("two_layers");
  endtask

  task automatic test_zero_count();
    int unsigned lay [2] = '{0, 2};
    int unsigned smp [2] = '{3, 0};
    for (int t = 0; t < 2; t++) begin
      pulse_start(lay[t], smp[t]);
      for (int c = 0; c <= 3; c++) begin
        if (c > 0) step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy t=%0d c=%0d: got %b expected 0", t, c, busy); end
        tests++; if (ctrl[VALID_BIT] !== 1'b0) begin fails++; $display("FAIL zero_valid t=%0d c=%0d: got %b expected 0", t, c, ctrl[VALID_BIT]); end
        tests++; if (done !== (c == 1)) begin fails++; $display("FAIL zero_done t=%0d c=%0d: got %b expected %b", t, c, done, (c == 1)); end
      end
    end
  endtask

  // One layer of four samples, stall high on edges 3..6
  task automatic test_stall();
    logic [CTRL_W-1:0] exp_ctrl;
    logic exp_ret, exp_busy, exp_done;
    pulse_start(1, 4);
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_ctrl = '0;
      if (c == 1) exp_ctrl = tok(1'b0, 0, 0);
      if (c == 2) exp_ctrl = tok(1'b0, 0, 1);
      if (c == 7) exp_ctrl = tok(1'b0, 0, 2);
      if (c == 8) exp_ctrl = tok(1'b1, 0, 3);
      exp_ret  = (c >= 11 && c <= 14);
      exp_busy = (c <= 13);
      exp_done = (c == 15);
      tests++; if (ctrl !== exp_ctrl) begin fails++; $display("FAIL stall_ctrl c=%0d: got %h expected %h", c, ctrl, exp_ctrl); end
      tests++; if (retire_valid !== exp_ret) begin fails++; $display("FAIL stall_retire c=%0d: got %b expected %b", c, retire_valid, exp_ret); end
      tests++; if (busy !== exp_busy) begin fails++; $display("FAIL stall_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
      tests++; if (done !== exp_done) begin fails++; $display("FAIL stall_done c=%0d: got %b expected %b", c, done, exp_done); end
      stall = (c >= 2 && c <= 5);
    end
`ifdef BACKPROP_SEQ_PERF_EN
    tests++; if (stall_cycles !== 32'd4) begin fails++; $display("FAIL stall_cycles: got %0d expected 4", stall_cycles); end
`endif
  endtask

  // Start re-pulsed with different counts on edge 4 (DRAIN) must be ignored
  task automatic test_restart_ignored();
    logic [CTRL_W-1:0] exp_ctrl;
    logic exp_ret, exp_busy, exp_done;
    pulse_start(1, 2);
`ifdef BACKPROP_SEQ_PERF_EN
    tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL restart_stall_clear: got %0d expected 0", stall_cycles); end
`endif
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_ctrl = '0;
      if (c == 1) exp_ctrl = tok(1'b0, 0, 0);
      if (c == 2) exp_ctrl = tok(1'b1, 0, 1);
      exp_ret  = (c == 7) || (c == 8);
      exp_busy = (c <= 7);
      exp_done = (c == 9);
      tests++; if (ctrl !== exp_ctrl) begin fails++; $display("FAIL restart_ctrl c=%0d: got %h expected %h", c, ctrl, exp_ctrl); end
      tests++; if (retire_valid !== exp_ret) begin fails++; $display("FAIL restart_retire c=%0d: got %b expected %b", c, retire_valid, exp_ret); end
      tests++; if (busy !== exp_busy) begin fails++; $display("FAIL restart_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
      tests++; if (done !== exp_done) begin fails++; $display("FAIL restart_done c=%0d: got %b expected %b", c, done, exp_done); end
      if (c == 3) begin
        layer_count  = IDX_W'(3);
        sample_count = IDX_W'(5);
        start        = 1'b1;
      end
      if (c == 4) start = 1'b0;
    end
  endtask

  task automatic test_reset_midrun();
    pulse_start(2, 3);
    step();
    tests++; if (ctrl !== tok(1'b0, 1, 0)) begin fails++; $display("FAIL midrun_tok0: got %h expected %h", ctrl, tok(1'b0, 1, 0)); end
    step();
    tests++; if (ctrl !== tok(1'b0, 1, 1)) begin fails++; $display("FAIL midrun_tok1: got %h expected %h", ctrl, tok(1'b0, 1, 1)); end
    rst_n = 1'b0;
    #1;
    tests++; if (ctrl !== '0) begin fails++; $display("FAIL midrun_async_ctrl: got %h expected 0", ctrl); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_async_busy: got %b expected 0", busy); end
    tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL midrun_async_retire: got %b expected 0", retire_valid); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrun_async_done: got %b expected 0", done); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_idle_busy c=%0d: got %b expected 0", c, busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrun_idle_done c=%0d: got %b expected 0", c, done); end
      tests++; if (ctrl !== '0) begin fails++; $display("FAIL midrun_idle_ctrl c=%0d: got %h expected 0", c, ctrl); end
      tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL midrun_idle_retire c=%0d: got %b expected 0", c, retire_valid); end
    end
    run_two_layer_seq("after_reset");
  endtask

  task automatic test_single();
    logic [CTRL_W-1:0] exp_ctrl;
    logic exp_ret, exp_busy, exp_done;
    pulse_start(1, 1);
    for (int c = 1; c <= 10; c++) begin
      step();
      exp_ctrl = (c == 1) ? tok(1'b1, 0, 0) : '0;
      exp_ret  = (c == 7);
      exp_busy = (c <= 6);
      exp_done = (c == 8);
      tests++; if (ctrl !== exp_ctrl) begin fails++; $display("FAIL single_ctrl c=%0d: got %h expected %h", c, ctrl, exp_ctrl); end
      tests++; if (retire_valid !== exp_ret) begin fails++; $display("FAIL single_retire c=%0d: got %b expected %b", c, retire_valid, exp_ret); end
      tests++; if (busy !== exp_busy) begin fails++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
      tests++; if (done !== exp_done) begin fails++; $display("FAIL single_done c=%0d: got %b expected %b", c, done, exp_done); end
    end
  endtask

  initial begin
    test_reset();
    test_two_layers();
    test_zero_count();
    test_stall();
    test_restart_ignored();
    test_reset_midrun();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
